// File: rtl/xb_io_txn_buffer.sv
// IO-bus transaction capture: address-window match per channel, records queued in a FIFO
// drained by valid/ready. Optional timestamp field enabled by XB_TXN_TIMESTAMP_EN.
module xb_io_txn_buffer #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1,
`ifdef XB_TXN_TIMESTAMP_EN
  localparam int TS_BITS = TS_W,
`else
  localparam int TS_BITS = TS_W * 0,
`endif
  localparam int REC_W = TS_BITS + CH_W + 1 + ADDR_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     en16mhz,
  input  logic                     clear,
  input  logic [ADDR_W-1:0]        io_adr,
  input  logic                     io_re,
  input  logic                     io_we,
  input  logic [DATA_W-1:0]        io_wdata,
  input  logic [DATA_W-1:0]        io_rdata,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_mask,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [REC_W-1:0]         rec_data,
  output logic [LVL_W-1:0]         level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              s1_re;
  logic              s1_we;
  logic [ADDR_W-1:0] s1_adr;
  logic [DATA_W-1:0] s1_wdata;
  logic [DATA_W-1:0] s1_rdata;

`ifdef XB_TXN_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] s1_ts;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ts_cnt <= '0;
      s1_ts  <= '0;
    end else if (clear) begin
      ts_cnt <= '0;
      s1_ts  <= '0;
    end else begin
      s1_ts <= ts_cnt;
      if (en16mhz) ts_cnt <= ts_cnt + TS_W'(1);
    end
  end
`else
  logic unused_en16mhz;
  assign unused_en16mhz = en16mhz;
`endif

  // Stage 1: pure capture, so the match logic never sees raw bus timing.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_re    <= 1'b0;
      s1_we    <= 1'b0;
      s1_adr   <= '0;
      s1_wdata <= '0;
      s1_rdata <= '0;
    end else if (clear) begin
      s1_re    <= 1'b0;
      s1_we    <= 1'b0;
      s1_adr   <= '0;
      s1_wdata <= '0;
      s1_rdata <= '0;
    end else begin
      s1_re    <= io_re;
      s1_we    <= io_we;
      s1_adr   <= io_adr;
      s1_wdata <= io_wdata;
      s1_rdata <= io_rdata;
    end
  end

  logic            hit;
  logic [CH_W-1:0] hit_ch;

  // Walk downwards so the lowest hitting channel is the last assignment.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[i] &&
          (((s1_adr ^ ch_base[i*ADDR_W +: ADDR_W]) & ch_mask[i*ADDR_W +: ADDR_W]) == '0)) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
  end

  logic              push;
  logic [DATA_W-1:0] s1_data;
  logic [REC_W-1:0]  rec_in;

  assign push    = hit && (s1_re || s1_we);
  assign s1_data = s1_we ? s1_wdata : s1_rdata;
`ifdef XB_TXN_TIMESTAMP_EN
  assign rec_in  = {s1_ts, hit_ch, s1_we, s1_adr, s1_data};
`else
  assign rec_in  = {hit_ch, s1_we, s1_adr, s1_data};
`endif

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             full;
  logic             pop;
  logic             wr;
  logic             drop;

  assign full = (level == LVL_W'(DEPTH));
  assign pop  = rec_valid && rec_ready;
  // When full, a same-cycle pop frees the slot the write pointer is aimed at.
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr && !clear) mem[wptr] <= rec_in;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr)  wptr <= wptr + PTR_W'(1);
      if (pop) rptr <= rptr + PTR_W'(1);
      if (wr && !pop)      level <= level + LVL_W'(1);
      else if (!wr && pop) level <= level - LVL_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Gating by occupancy keeps rec_data at zero after reset/clear without resetting the array.
  assign rec_valid = (level != '0);
  assign rec_data  = rec_valid ? mem[rptr] : '0;

endmodule

// File: doc/xb_io_txn_buffer.md
Name: xb_io_txn_buffer

Overview:
- Parametrised, buffered successor to the per-cycle sample/drive core wrapper.
- Sits beside the AVR core on the IO-arbiter (FP) bus and captures IO read/write transactions that hit programmable address windows, one window per channel.
- Each capture becomes a timestamped record in a FIFO. A consumer (XB logic or a DPI/testbench monitor) drains the FIFO through a valid/ready handshake, so no cycle-by-cycle sampling is needed.

Parameters:
- NUM_CH, 4: number of address-match channels (1..8); CH_W = max(1, clog2(NUM_CH)).
- ADDR_W, 6: IO address width.
- DATA_W, 8: IO data width.
- DEPTH, 16: FIFO depth in records; power of 2, at least 2.
- TS_W, 16: timestamp counter width.

Ports:
- clk  in  1  core clock.
- nrst  in  1  asynchronous active-low reset.
- en16mhz  in  1  timestamp tick enable.
- clear  in  1  synchronous flush of FIFO, counters and flags.
- io_adr  in  ADDR_W  IO address (io_arb_mux_adr).
- io_re  in  1  IO read strobe.
- io_we  in  1  IO write strobe.
- io_wdata  in  DATA_W  write data (io_arb_mux_dbusout).
- io_rdata  in  DATA_W  read-return data (stgi_xf_io_slv_dbusout).
- ch_base  in  NUM_CH*ADDR_W  per-channel base address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_mask  in  NUM_CH*ADDR_W  per-channel compare mask; 1 = bit compared.
- ch_en  in  NUM_CH  per-channel enable.
- rec_valid  out  1  head record available.
- rec_ready  in  1  consumer accepts the head record.
- rec_data  out  REC_W  {ts, ch, we, adr, data}. REC_W = TS_W + CH_W + 1 + ADDR_W + DATA_W, or without ts when the option is off.
- level  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one record dropped.
- drop_cnt  out  8  count of dropped records, saturating.

Behaviour:
- Reset (nrst low, asynchronous): rec_valid=0, rec_data=0, level=0, overflow=0, drop_cnt=0, timestamp=0, stage-1 register cleared.
- Timestamp:
  - Increments by 1 on each clk edge where en16mhz=1.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Stage 1 (cycle N): register io_adr, io_re, io_we, io_wdata, io_rdata and the timestamp value at cycle N.
- Stage 2 (cycle N+1): match and enqueue.
  - Channel i hits when ch_en[i] && ((adr ^ ch_base[i]) & ch_mask[i]) == 0.
  - The lowest hitting index wins.
  - A strobe with no hit is discarded silently.
- Record contents:
  - we=1 if io_we, with data=wdata.
  - Otherwise, if io_re: we=0, data=rdata.
  - io_we and io_re both high produce a single write record.
  - Neither strobe: no record.
- Latency: with an empty FIFO, a hit at cycle N gives rec_valid=1 at N+2 with rec_data valid. rec_data is driven from the FIFO head register, with no combinational path from the io_* inputs.
- Handshake:
  - Pop occurs when rec_valid && rec_ready.
  - rec_data and rec_valid hold stable while rec_valid && !rec_ready.
  - rec_ready with rec_valid=0 has no effect.
- Full (level==DEPTH):
  - A push without a same-cycle pop is dropped: overflow<=1, drop_cnt increments, saturating at 255.
  - A push with a same-cycle pop is accepted and level stays at DEPTH.
- Empty: push and pop cannot coincide on the same record. A push into an empty FIFO becomes visible the next cycle.
- Level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers: read and write pointers wrap modulo DEPTH.
- clear:
  - Takes priority over a push and a pop in the same cycle.
  - Next cycle: level=0, rec_valid=0, overflow=0, drop_cnt=0, timestamp=0.
  - The stage-1 register is also flushed, so a transaction captured the cycle before clear is lost.
- Reset mid-operation: all state returns to reset values immediately, and the FIFO contents are discarded.
- Config changes: changes to ch_base, ch_mask and ch_en take effect on the stage-2 compare in the cycle they change.

Optional Feature:
- Macro: XB_TXN_TIMESTAMP_EN.
- Defined:
  - Timestamp counter present and ts field included.
  - REC_W = TS_W + CH_W + 1 + ADDR_W + DATA_W.
- Undefined:
  - No timestamp counter; en16mhz is ignored.
  - REC_W = CH_W + 1 + ADDR_W + DATA_W.
  - All other behaviour is identical.

Test Plan:
1. Single write:
   - Setup: ch_en=0001, ch_base[0]=0x25, ch_mask[0]=0x3F, rec_ready=0.
   - Stimulus: io_we with adr=0x25, wdata=0xA5 at cycle N.
   - Required: rec_valid=1 at N+2 with ch=0, we=1, adr=0x25, data=0xA5, and ts equal to the timestamp value at N.
2. Priority and read capture:
   - Setup: ch0 and ch2 both enabled with mask=0x30, base=0x20.
   - Stimulus: io_re at adr=0x2B, rdata=0x3C.
   - Required: exactly one record with ch=0, we=0, data=0x3C.
   - Stimulus: adr=0x10.
   - Required: no record.
3. Overflow:
   - Setup: DEPTH=16, rec_ready=0.
   - Stimulus: 20 consecutive hitting writes.
   - Required: level=16, overflow=1, drop_cnt=4. Draining yields the first 16 records in order.
4. Full with simultaneous pop:
   - Setup: full FIFO, rec_ready=1.
   - Stimulus: hitting write each cycle for 5 cycles.
   - Required: level stays 16, drop_cnt unchanged, no record lost.
5. Backpressure stability:
   - Stimulus: toggle rec_ready 1/0 every cycle during a 10-record burst.
   - Required: rec_data stable while rec_ready=0, all 10 records received in order.
6. clear and reset:
   - Stimulus: assert clear at the same cycle as a push and a pop.
   - Required: next cycle level=0, overflow=0, drop_cnt=0.
   - Stimulus: async nrst pulse mid-burst.
   - Required: rec_valid=0 immediately.
